// File: rtl/vie_cp0_pkg.sv
// rtl/vie_cp0_pkg.sv - CP0 register addresses, exception codes and field positions
package vie_cp0_pkg;

  // CP0 register addresses, encoded as {reg[4:0], sel[2:0]}
  localparam logic [7:0] CR_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] CR_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] CR_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] CR_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] CR_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] CR_EPC      = {5'd14, 3'd0};

  // ExcCode values written into Cause
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_t;

  // Bit positions inside cm_exc = {adel, ades, ov, sys, bp, ri}
  localparam int EXB_ADEL = 5;
  localparam int EXB_ADES = 4;
  localparam int EXB_OV   = 3;
  localparam int EXB_SYS  = 2;
  localparam int EXB_BP   = 1;
  localparam int EXB_RI   = 0;

  // Status field positions
  localparam int ST_BEV   = 22;
  localparam int ST_IM_LO = 8;
  localparam int ST_EXL   = 1;
  localparam int ST_IE    = 0;

  // Cause field positions
  localparam int CA_BD     = 31;
  localparam int CA_TI     = 30;
  localparam int CA_IP_LO  = 8;
  localparam int CA_EXC_LO = 2;

  // Fixed priority: interrupt, adel, ades, sys, bp, ri, ov
  function automatic exc_code_t exc_pick(input logic int_req, input logic [5:0] exc);
    if (int_req)             return EXC_INT;
    else if (exc[EXB_ADEL])  return EXC_ADEL;
    else if (exc[EXB_ADES])  return EXC_ADES;
    else if (exc[EXB_SYS])   return EXC_SYS;
    else if (exc[EXB_BP])    return EXC_BP;
    else if (exc[EXB_RI])    return EXC_RI;
    else                     return EXC_OV;
  endfunction

endpackage

// File: rtl/vie_cp0_ctrl_if.sv
// rtl/vie_cp0_ctrl_if.sv - commit, CP0 read and flush bus between pipeline and CP0
interface vie_cp0_ctrl_if;

  logic        cm_valid;
  logic [5:0]  cm_exc;
  logic        cm_bd;
  logic [31:0] cm_pc;
  logic [31:0] cm_baddr;
  logic        cm_eret;
  logic        cm_mtc0;
  logic [7:0]  cm_waddr;
  logic [31:0] cm_wdata;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic        flush;
  logic [31:0] flush_target;

  modport master (
    output cm_valid, cm_exc, cm_bd, cm_pc, cm_baddr, cm_eret, cm_mtc0,
           cm_waddr, cm_wdata, rd_addr,
    input  rd_data, flush, flush_target
  );

  modport slave (
    input  cm_valid, cm_exc, cm_bd, cm_pc, cm_baddr, cm_eret, cm_mtc0,
           cm_waddr, cm_wdata, rd_addr,
    output rd_data, flush, flush_target
  );

endinterface

// File: rtl/vie_cp0_timer.sv
// rtl/vie_cp0_timer.sv - prescaled Count/Compare timer with timer interrupt flag
module vie_cp0_timer #(
  parameter int TIMER_DIV = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam logic [3:0] PRESC_MAX = 4'(TIMER_DIV - 1);

  logic [3:0]  presc_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic [31:0] count_inc;
  logic        ti_q;
  logic        tick;

  assign tick      = (presc_q == PRESC_MAX);
  assign count_inc = count_q + 32'd1;

  // Prescaler and Count; a software Count write wins and restarts the prescaler
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      count_q <= '0;
    end else if (count_we) begin
      presc_q <= '0;
      count_q <= wdata;
    end else begin
      presc_q <= tick ? 4'd0 : presc_q + 4'd1;
      if (tick) count_q <= count_inc;
    end
  end

  // Compare register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          compare_q <= '0;
    else if (compare_we) compare_q <= wdata;
  end

  // TI sets only when a hardware increment lands on Compare; a Compare write clears it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                                ti_q <= 1'b0;
    else if (compare_we)                                       ti_q <= 1'b0;
    else if (tick && !count_we && (count_inc == compare_q))    ti_q <= 1'b1;
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;

endmodule

// File: rtl/vie_cp0_ctrl.sv
// rtl/vie_cp0_ctrl.sv - CP0 register file and exception/interrupt controller at commit
module vie_cp0_ctrl
  import vie_cp0_pkg::*;
#(
  parameter int          EXT_INT_W   = 6,
  parameter int          SYNC_STAGES = 2,
  parameter int          TIMER_DIV   = 2,
  parameter int          TIMER_IP7   = 1,
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [EXT_INT_W-1:0] ext_int_in,
  vie_cp0_ctrl_if.slave        cp,
  output logic                 exl,
  output logic                 int_pending,
  output logic                 timer_int
);

  logic [EXT_INT_W-1:0] ext_sync;
  logic [5:0]           ext_wide;
  logic [5:0]           ip_ext_q;
  logic [1:0]           ip_sw_q;
  logic [7:0]           ip;
  logic                 ip7_ti;

  logic [7:0]  im_q;
  logic        exl_q;
  logic        ie_q;
  logic        bd_q;
  exc_code_t   exc_code_q;
  logic [31:0] epc_q;
  logic [31:0] badvaddr_q;
  logic        flush_q;
  logic [31:0] flush_target_q;

  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;

  logic        take_exc;
  logic        do_eret;
  logic        mtc0_we;
  exc_code_t   exc_code;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_epc;
  logic [31:0] status_word;
  logic [31:0] cause_word;
  logic [31:0] rd_word;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign ext_sync = ext_int_in;
    end else begin : g_sync
      logic [EXT_INT_W-1:0] sync_q [SYNC_STAGES];
      // Metastability chain on the asynchronous interrupt lines
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= ext_int_in;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign ext_sync = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Widen synced lines to the six hardware IP slots; missing lines read 0
  always_comb begin
    ext_wide = '0;
    ext_wide[EXT_INT_W-1:0] = ext_sync;
  end

  // Hardware IP[7:2] capture stage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ip_ext_q <= '0;
    else        ip_ext_q <= ext_wide;
  end

  assign ip7_ti = (TIMER_IP7 != 0) ? ti : 1'b0;
  assign ip     = {ip_ext_q[5] | ip7_ti, ip_ext_q[4:0], ip_sw_q};

  assign int_pending = (|(ip & im_q)) & ie_q & ~exl_q;
  assign take_exc    = cp.cm_valid & ((|cp.cm_exc) | int_pending);
  assign do_eret     = cp.cm_valid & cp.cm_eret & ~take_exc;
  assign mtc0_we     = cp.cm_valid & cp.cm_mtc0 & ~take_exc;
  assign exc_code    = exc_pick(int_pending, cp.cm_exc);

  assign wr_status  = mtc0_we && (cp.cm_waddr == CR_STATUS);
  assign wr_cause   = mtc0_we && (cp.cm_waddr == CR_CAUSE);
  assign wr_count   = mtc0_we && (cp.cm_waddr == CR_COUNT);
  assign wr_compare = mtc0_we && (cp.cm_waddr == CR_COMPARE);
  assign wr_epc     = mtc0_we && (cp.cm_waddr == CR_EPC);

  vie_cp0_timer #(
    .TIMER_DIV (TIMER_DIV)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .count_we   (wr_count),
    .compare_we (wr_compare),
    .wdata      (cp.cm_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  // Status: exception sets EXL, ERET clears it, software write applies otherwise
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      im_q  <= '0;
      ie_q  <= 1'b0;
      exl_q <= 1'b0;
    end else begin
      if (wr_status) begin
        im_q <= cp.cm_wdata[ST_IM_LO +: 8];
        ie_q <= cp.cm_wdata[ST_IE];
      end
      if (take_exc)       exl_q <= 1'b1;
      else if (do_eret)   exl_q <= 1'b0;
      else if (wr_status) exl_q <= cp.cm_wdata[ST_EXL];
    end
  end

  // Cause, EPC and BadVAddr updates; nested exceptions keep the original EPC and BD
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ip_sw_q    <= '0;
      bd_q       <= 1'b0;
      exc_code_q <= EXC_INT;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      if (wr_cause) ip_sw_q <= cp.cm_wdata[CA_IP_LO +: 2];
      if (take_exc) begin
        exc_code_q <= exc_code;
        if (exc_code == EXC_ADEL || exc_code == EXC_ADES) badvaddr_q <= cp.cm_baddr;
        if (!exl_q) begin
          epc_q <= cp.cm_bd ? cp.cm_pc - 32'd4 : cp.cm_pc;
          bd_q  <= cp.cm_bd;
        end
      end else if (wr_epc) begin
        epc_q <= cp.cm_wdata;
      end
    end
  end

  // Registered flush pulse; ERET returns to the EPC seen at commit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flush_q        <= 1'b0;
      flush_target_q <= EXC_VECTOR;
    end else begin
      flush_q <= take_exc | do_eret;
      if (take_exc)     flush_target_q <= EXC_VECTOR;
      else if (do_eret) flush_target_q <= epc_q;
    end
  end

  // Assemble Status and Cause words; BEV is hard-wired to the boot setting
  always_comb begin
    status_word = '0;
    status_word[ST_BEV]          = 1'b1;
    status_word[ST_IM_LO +: 8]   = im_q;
    status_word[ST_EXL]          = exl_q;
    status_word[ST_IE]           = ie_q;
    cause_word = '0;
    cause_word[CA_BD]            = bd_q;
    cause_word[CA_TI]            = ti;
    cause_word[CA_IP_LO +: 8]    = ip;
    cause_word[CA_EXC_LO +: 5]   = exc_code_q;
  end

  // MFC0 read mux; unimplemented addresses read 0
  always_comb begin
    rd_word = '0;
    case (cp.rd_addr)
      CR_BADVADDR: rd_word = badvaddr_q;
      CR_COUNT:    rd_word = count;
      CR_COMPARE:  rd_word = compare;
      CR_STATUS:   rd_word = status_word;
      CR_CAUSE:    rd_word = cause_word;
      CR_EPC:      rd_word = epc_q;
      default:     rd_word = '0;
    endcase
  end

  assign cp.rd_data      = rd_word;
  assign cp.flush        = flush_q;
  assign cp.flush_target = flush_target_q;
  assign exl             = exl_q;
  assign timer_int       = ti;

endmodule

// File: tb/tb_vie_cp0_ctrl.sv
// tb/tb_vie_cp0_ctrl.sv - scoreboard bench for vie_cp0_ctrl
module tb_vie_cp0_ctrl;
  import vie_cp0_pkg::*;

  localparam logic [31:0] VEC = 32'hBFC00380;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] ext_int_in;
  logic       exl;
  logic       int_pending;
  logic       timer_int;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  vie_cp0_ctrl_if cp();

  vie_cp0_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .ext_int_in  (ext_int_in),
    .cp          (cp),
    .exl         (exl),
    .int_pending (int_pending),
    .timer_int   (timer_int)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Flush monitor: every pulse must match the oldest expected target
  always @(negedge clock) begin
    if (reset && cp.flush) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_flush actual_target=%h expected=no_flush", cp.flush_target);
      end else begin
        mon_exp = exp_q.pop_front();
        if (cp.flush_target !== mon_exp) begin
          failures++;
          $display("FAIL flush_target actual=%h expected=%h", cp.flush_target, mon_exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic idle_bus();
    cp.cm_valid = 1'b0; cp.cm_exc = '0; cp.cm_bd = 1'b0; cp.cm_pc = '0;
    cp.cm_baddr = '0; cp.cm_eret = 1'b0; cp.cm_mtc0 = 1'b0;
    cp.cm_waddr = '0; cp.cm_wdata = '0;
  endtask

  task automatic commit(input logic [5:0] exc, input logic bd, input logic [31:0] pc,
                        input logic [31:0] baddr, input logic is_eret, input logic is_mtc0,
                        input logic [7:0] waddr, input logic [31:0] wdata);
    cp.cm_valid = 1'b1; cp.cm_exc = exc; cp.cm_bd = bd; cp.cm_pc = pc;
    cp.cm_baddr = baddr; cp.cm_eret = is_eret; cp.cm_mtc0 = is_mtc0;
    cp.cm_waddr = waddr; cp.cm_wdata = wdata;
    tick(1);
    idle_bus();
  endtask

  task automatic wr_cp0(input logic [7:0] a, input logic [31:0] d);
    commit(6'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, a, d);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    cp.rd_addr = a;
    #1;
    check(name, cp.rd_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_bus();
    cp.rd_addr = '0;
    ext_int_in = '0;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    check("rst_flush", 32'(cp.flush), 32'h0);
    check("rst_target", cp.flush_target, VEC);
    check("rst_exl", 32'(exl), 32'h0);
    check("rst_ti", 32'(timer_int), 32'h0);
    check("rst_intp", 32'(int_pending), 32'h0);

    tick(10);
    rd_chk("status_rst", CR_STATUS, 32'h00400000);
    rd_chk("cause_rst", CR_CAUSE, 32'h0);
    rd_chk("count_10cyc", CR_COUNT, 32'd5);

    // adel in a delay slot
    exp_q.push_back(VEC);
    commit(6'b100000, 1'b1, 32'h1000, 32'h3, 1'b0, 1'b0, 8'h0, 32'h0);
    rd_chk("adel_epc", CR_EPC, 32'h0FFC);
    rd_chk("adel_cause", CR_CAUSE, 32'h80000010);
    rd_chk("adel_badv", CR_BADVADDR, 32'h3);
    check("adel_exl", 32'(exl), 32'h1);

    // nested exception with ov|bp|ri -> bp wins, EPC/BD hold
    exp_q.push_back(VEC);
    commit(6'b001011, 1'b0, 32'h2000, 32'h99, 1'b0, 1'b0, 8'h0, 32'h0);
    rd_chk("nest_epc", CR_EPC, 32'h0FFC);
    rd_chk("nest_cause", CR_CAUSE, 32'h80000024);
    rd_chk("nest_badv", CR_BADVADDR, 32'h3);
    exp_q.push_back(32'h0FFC);
    commit(6'b0, 1'b0, 32'h2004, 32'h0, 1'b1, 1'b0, 8'h0, 32'h0);
    check("eret_exl", 32'(exl), 32'h0);

    // timer interrupt
    wr_cp0(CR_STATUS, 32'h8001);
    rd_chk("status_wr", CR_STATUS, 32'h00408001);
    wr_cp0(CR_COMPARE, 32'd20);
    wr_cp0(CR_COUNT, 32'd0);
    tick(39);
    check("ti_before", 32'(timer_int), 32'h0);
    rd_chk("count_19", CR_COUNT, 32'd19);
    tick(1);
    check("ti_set", 32'(timer_int), 32'h1);
    check("ti_intp", 32'(int_pending), 32'h1);
    rd_chk("count_20", CR_COUNT, 32'd20);
    exp_q.push_back(VEC);
    commit(6'b0, 1'b0, 32'h3000, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    check("int_exl", 32'(exl), 32'h1);
    check("int_intp_off", 32'(int_pending), 32'h0);
    rd_chk("int_epc", CR_EPC, 32'h3000);
    rd_chk("int_cause", CR_CAUSE, 32'h40008000);
    wr_cp0(CR_COMPARE, 32'd100);
    check("ti_clear", 32'(timer_int), 32'h0);
    rd_chk("cause_ti_clr", CR_CAUSE, 32'h0);

    // software IP bits, ignored BadVAddr write, external interrupt latency
    exp_q.push_back(32'h3000);
    commit(6'b0, 1'b0, 32'h3100, 32'h0, 1'b1, 1'b0, 8'h0, 32'h0);
    wr_cp0(CR_STATUS, 32'h0801);
    wr_cp0(CR_CAUSE, 32'h0303);
    rd_chk("cause_ipsw", CR_CAUSE, 32'h0300);
    wr_cp0(CR_CAUSE, 32'h0);
    wr_cp0(CR_BADVADDR, 32'hDEAD);
    rd_chk("badv_ro", CR_BADVADDR, 32'h3);
    ext_int_in = 6'b000010;
    tick(2);
    check("ext_lat2", 32'(int_pending), 32'h0);
    tick(1);
    check("ext_lat3", 32'(int_pending), 32'h1);
    rd_chk("ext_cause", CR_CAUSE, 32'h0800);
    ext_int_in = '0;
    tick(3);
    check("ext_drop", 32'(int_pending), 32'h0);

    // adel + MTC0 EPC + ERET together: exception wins
    exp_q.push_back(VEC);
    commit(6'b100000, 1'b0, 32'h4000, 32'h44, 1'b1, 1'b1, CR_EPC, 32'h55);
    check("combo_exl", 32'(exl), 32'h1);
    rd_chk("combo_epc", CR_EPC, 32'h4000);
    rd_chk("combo_badv", CR_BADVADDR, 32'h44);
    rd_chk("combo_cause", CR_CAUSE, 32'h00000010);

    // reset asserted while a flush is being presented
    commit(6'b000001, 1'b0, 32'h5000, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    check("pre_rst_flush", 32'(cp.flush), 32'h1);
    reset = 1'b0;
    #1;
    check("mid_rst_flush", 32'(cp.flush), 32'h0);
    check("mid_rst_target", cp.flush_target, VEC);
    check("mid_rst_exl", 32'(exl), 32'h0);
    tick(2);
    reset = 1'b1;
    rd_chk("post_rst_status", CR_STATUS, 32'h00400000);
    rd_chk("post_rst_epc", CR_EPC, 32'h0);
    tick(2);

    check("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vie_cp0_ctrl.md
Name: vie_cp0_ctrl

Overview:
Parametrised coprocessor-0 register file and exception/interrupt controller, split out of the write-back stage. It sits at the commit point after the memory stage. It accepts one committing instruction per cycle with its exception flags, MTC0/ERET controls and a read address. It produces a registered pipeline flush with target, plus interrupt/kernel status. It adds several things the earlier integrated version lacked: configurable interrupt width, synchroniser depth, timer prescale, exception vector, and a self-contained Count/Compare timer.

Parameters:
EXT_INT_W, 6, number of external interrupt lines (1..6); they map to IP[2+EXT_INT_W-1:2], and unused IP bits read 0.
SYNC_STAGES, 2, flop stages on ext_int_in (0 = none, max 3).
TIMER_DIV, 2, Count increments once every TIMER_DIV cycles (1..16).
TIMER_IP7, 1, when 1, IP7 = synced ext[5] OR Cause.TI.
EXC_VECTOR, 32'hBFC00380, flush target for every exception.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
ext_int_in  in  EXT_INT_W  raw external interrupt requests
cm_valid  in  1  an instruction commits this cycle
cm_exc  in  6  {adel,ades,ov,sys,bp,ri}
cm_bd  in  1  committing instruction is in a delay slot
cm_pc  in  32  committing instruction PC
cm_baddr  in  32  faulting address for adel/ades
cm_eret  in  1  committing instruction is ERET
cm_mtc0  in  1  committing instruction is MTC0
cm_waddr  in  8  {reg[4:0],sel[2:0]} MTC0 target
cm_wdata  in  32  MTC0 data
rd_addr  in  8  MFC0 source address
rd_data  out  32  combinational read data (0 for unimplemented registers)
flush  out  1  one-cycle pipeline flush pulse
flush_target  out  32  PC to fetch after flush
exl  out  1  Status.EXL (kernel/exception level)
int_pending  out  1  interrupt will be taken at the next valid commit
timer_int  out  1  Cause.TI

Behaviour:
- Reset (reset=0, asynchronous):
  - Status: BEV=1, IM=0, EXL=0, IE=0.
  - Cause, Count, Compare, EPC, BadVAddr, prescaler and synchroniser flops all 0.
  - flush=0, flush_target=EXC_VECTOR.
  - A flush pending when reset asserts is dropped.
- Registers: BadVAddr(8,0), Count(9,0), Compare(11,0), Status(12,0), Cause(13,0), EPC(14,0).
  - Status layout: {9'b0,BEV,6'b0,IM[7:0],6'b0,EXL,IE}.
  - Cause layout: {BD,TI,14'b0,IP[7:0],1'b0,ExcCode[4:0],2'b0}.
- Interrupt: int_pending = |(IP & IM) & IE & ~EXL. IP[7:2] comes from the synchronised inputs, so latency from input change to IP is SYNC_STAGES+1 cycles. IP[1:0] is software-writable.
- Exception taken (take_exc) = cm_valid & (|cm_exc | int_pending).
  - Priority: int(0) > adel(4) > ades(5) > sys(8) > bp(9) > ri(10) > ov(12).
  - ExcCode is written with the winning code.
  - BadVAddr <= cm_baddr only when the winner is adel or ades.
  - If EXL=0: EPC <= cm_bd ? cm_pc-4 : cm_pc, and Cause.BD <= cm_bd. If EXL=1, EPC and BD hold (nested exception).
  - EXL <= 1.
  - Next cycle: flush=1, flush_target=EXC_VECTOR.
- ERET (cm_valid & cm_eret & ~take_exc): EXL <= 0. Next cycle: flush=1, flush_target = EPC value at commit.
- MTC0 (cm_valid & cm_mtc0 & ~take_exc) is written at the clock edge.
  - Writable fields: Status IM/EXL/IE, Cause IP[1:0], Count, Compare, EPC.
  - Writes to BadVAddr and unimplemented addresses are ignored.
- Simultaneous events:
  - Exception beats ERET and MTC0.
  - MTC0 EXL write is overridden by exception/ERET.
  - Hardware Count increment loses to an MTC0 Count write; that write also clears the prescaler.
- Timer:
  - Prescaler counts 0..TIMER_DIV-1; Count increments on wrap, with 32-bit wrap-around.
  - TI is set on the cycle Count increments to a value equal to Compare. There is no spurious set at reset when both are 0.
  - A Compare write clears TI (clear wins over set).
- flush is a single-cycle pulse. Back-to-back commits may produce consecutive pulses. cm_valid=0 never produces a flush.

Decomposition:
- Package vie_cp0_pkg holds:
  - CR_* register addresses
  - EXC_* ExcCode constants
  - cm_exc bit indices
  - Status/Cause field positions
- Sub-module vie_cp0_timer contains the prescaler, Count, Compare and TI logic.
- Synchroniser and register file stay in the top level.

Test Plan:
- Reset release, cm_valid=0 for 10 cycles, read 12/13/9 (TIMER_DIV=2) → Status=32'h00400000, Cause=0, Count=5, flush never 1.
- cm_exc=adel, cm_bd=1, cm_pc=32'h1000, cm_baddr=32'h3 → next cycle flush=1, target 32'hBFC00380; EPC=32'h0FFC, BD=1, ExcCode=4, BadVAddr=3, EXL=1.
- Second exception while EXL=1, cm_pc=32'h2000 → flush=1 to vector, EPC stays 32'h0FFC; ERET then → flush target 32'h0FFC, EXL=0.
- MTC0 Compare=20, Status=32'h8001 → TI=1 when Count reaches 20, int_pending=1; next valid commit takes ExcCode 0; Compare rewrite clears TI.
- ext_int_in[1] pulsed with IM[3]=1, IE=1 → int_pending rises exactly SYNC_STAGES+1 cycles later.
- Same-cycle adel + MTC0 EPC=32'h55 and ERET → exception taken, EPC from cm_pc, write discarded; reset asserted mid-flush → flush=0 immediately.
